// File: rtl/twiddle_rd_sched.sv
// Read scheduler for the four-lane recover-stage twiddle ROM bank.
// Sweeps column 1 over k = 0..L-1 and column 2 over (L-k) mod L, honours
// downstream stall, and tracks in-flight reads so data_vld/data_idx line up
// with the ROM's registered output.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; an accepted start may issue row 0 at once
// ISSUE  | one ROM read per unstalled cycle until row L-1 is issued
// DRAIN  | waiting ROM_LAT cycles for in-flight reads, then pulse done
module twiddle_rd_sched #(
  parameter int ADDR_W  = 11,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic              stall,
  output logic              rom_valid,
  output logic [ADDR_W-1:0] rom_addr_col1,
  output logic [ADDR_W-1:0] rom_addr_col2,
  output logic              data_vld,
  output logic [ADDR_W-1:0] data_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_len, w_len_nxt;
  logic [ADDR_W-1:0] r_k, w_k_nxt;
  logic [ADDR_W-1:0] w_len_cur, w_k_cur;
  logic [2:0]        r_cnt, w_cnt_nxt;
  logic              w_issue;
  logic              r_rom_valid, w_rom_valid_nxt;
  logic [ADDR_W-1:0] r_addr1, w_addr1_nxt;
  logic [ADDR_W-1:0] r_addr2, w_addr2_nxt;
  logic              r_busy, r_done, w_done_nxt;
  logic              r_sr_vld [ROM_LAT];
  logic [ADDR_W-1:0] r_sr_idx [ROM_LAT];

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_k         <= '0;
      r_cnt       <= '0;
      r_rom_valid <= 1'b0;
      r_addr1     <= '0;
      r_addr2     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_k         <= w_k_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rom_valid <= w_rom_valid_nxt;
      r_addr1     <= w_addr1_nxt;
      r_addr2     <= w_addr2_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
    end
  end

  // Next-state and issue decision; an accepted start issues row 0 in the
  // same edge so the first read lands one cycle after start.
  always_comb begin
    w_len_cur       = (r_state == S_IDLE) ? cfg_len : r_len;
    w_k_cur         = (r_state == S_IDLE) ? '0 : r_k;
    w_issue         = !stall && ((r_state == S_ISSUE) ||
                                 ((r_state == S_IDLE) && start && (cfg_len != '0)));
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_k_nxt         = r_k;
    w_cnt_nxt       = r_cnt;
    w_rom_valid_nxt = 1'b0;
    w_addr1_nxt     = r_addr1;
    w_addr2_nxt     = r_addr2;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_len_nxt = cfg_len;
          w_k_nxt   = '0;
          if (cfg_len == '0) begin
            w_state_nxt = S_DRAIN;
            w_cnt_nxt   = 3'd0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: ;
      S_DRAIN: begin
        w_done_nxt = (r_cnt == 3'd1);
        if (r_cnt == 3'd0) w_state_nxt = S_IDLE;
        else               w_cnt_nxt   = r_cnt - 3'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_issue) begin
      w_rom_valid_nxt = 1'b1;
      w_addr1_nxt     = w_k_cur;
      w_addr2_nxt     = (w_k_cur == '0) ? '0 : (w_len_cur - w_k_cur);
      w_k_nxt         = w_k_cur + ADDR_W'(1);
      if (w_k_cur == (w_len_cur - ADDR_W'(1))) begin
        w_state_nxt = S_DRAIN;
        w_cnt_nxt   = 3'(ROM_LAT);
      end
    end
  end

  // In-flight read tracker; never stalls, so its tail follows the ROM output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        r_sr_vld[i] <= 1'b0;
        r_sr_idx[i] <= '0;
      end
    end else begin
      r_sr_vld[0] <= r_rom_valid;
      r_sr_idx[0] <= r_addr1;
      for (int i = 1; i < ROM_LAT; i++) begin
        r_sr_vld[i] <= r_sr_vld[i-1];
        r_sr_idx[i] <= r_sr_idx[i-1];
      end
    end
  end

  assign rom_valid     = r_rom_valid;
  assign rom_addr_col1 = r_addr1;
  assign rom_addr_col2 = r_addr2;
  assign data_vld      = r_sr_vld[ROM_LAT-1];
  assign data_idx      = r_sr_idx[ROM_LAT-1];
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
